// File: rtl/stump_control_ws.sv
// STUMP control unit with wait states: FETCH/EXECUTE/MEMORY one-hot FSM plus
// instruction decode. Accesses stretch by WAIT_CYCLES and, optionally, mem_ready.
module stump_control_ws #(
   parameter int WAIT_CYCLES = 0,
   parameter int WAIT_W      = 4,
   parameter bit USE_READY   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  cc,
   input  logic [15:0] ir,
   input  logic        mem_ready,
   output logic        fetch,
   output logic        execute,
   output logic        memory,
   output logic        stall,
   output logic        ext_op,
   output logic        reg_write,
   output logic [2:0]  dest,
   output logic [2:0]  srcA,
   output logic [2:0]  srcB,
   output logic [1:0]  shift_op,
   output logic        opB_mux_sel,
   output logic [2:0]  alu_func,
   output logic        cc_en,
   output logic        mem_ren,
   output logic        mem_wen
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'b001,
      S_EXECUTE = 3'b010,
      S_MEMORY  = 3'b100
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_CYCLES[WAIT_W-1:0];

   state_t            r_state;
   state_t            w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;

   logic [2:0] w_op;
   logic       w_type;
   logic       w_sl;
   logic [2:0] w_rd;
   logic [2:0] w_ra;
   logic [2:0] w_rb;
   logic [1:0] w_sh;
   logic [3:0] w_cond;
   logic       w_is_ldst;
   logic       w_is_bcc;
   logic       w_is_alu;
   logic       w_access;
   logic       w_complete;
   logic       w_cond_true;
   logic       w_n, w_z, w_v, w_c;

   assign w_op      = ir[15:13];
   assign w_type    = ir[12];
   assign w_sl      = ir[11];
   assign w_rd      = ir[10:8];
   assign w_ra      = ir[7:5];
   assign w_rb      = ir[4:2];
   assign w_sh      = ir[1:0];
   assign w_cond    = ir[11:8];
   assign w_is_ldst = (w_op == 3'b110);
   assign w_is_bcc  = (w_op == 3'b111);
   assign w_is_alu  = !w_is_ldst && !w_is_bcc;
   assign {w_n, w_z, w_v, w_c} = cc;

   assign w_access   = (r_state == S_FETCH) || (r_state == S_MEMORY);
   assign w_complete = (r_wait_cnt == WAIT_MAX) && (mem_ready || !USE_READY);

   // Counter is cleared whenever the current access ends (or in EXECUTE),
   // so it always starts from zero on entry to FETCH/MEMORY.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_access && !w_complete) begin
            if (r_wait_cnt != WAIT_MAX)
               r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH:   if (w_complete) w_state_next = S_EXECUTE;
         S_EXECUTE: w_state_next = w_is_ldst ? S_MEMORY : S_FETCH;
         S_MEMORY:  if (w_complete) w_state_next = S_FETCH;
         default:   w_state_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_cond_true = 1'b0;
      case (w_cond)
         4'h0: w_cond_true = 1'b1;
         4'h1: w_cond_true = 1'b0;
         4'h2: w_cond_true = !w_c && !w_z;
         4'h3: w_cond_true = w_c || w_z;
         4'h4: w_cond_true = !w_c;
         4'h5: w_cond_true = w_c;
         4'h6: w_cond_true = !w_z;
         4'h7: w_cond_true = w_z;
         4'h8: w_cond_true = !w_v;
         4'h9: w_cond_true = w_v;
         4'hA: w_cond_true = !w_n;
         4'hB: w_cond_true = w_n;
         4'hC: w_cond_true = (w_n == w_v);
         4'hD: w_cond_true = (w_n != w_v);
         4'hE: w_cond_true = !w_z && (w_n == w_v);
         4'hF: w_cond_true = w_z || (w_n != w_v);
         default: w_cond_true = 1'b0;
      endcase
   end

   assign {memory, execute, fetch} = r_state;

   always_comb begin
      stall       = 1'b0;
      ext_op      = 1'b0;
      reg_write   = 1'b0;
      dest        = 3'd0;
      srcA        = 3'd0;
      srcB        = 3'd0;
      shift_op    = 2'b00;
      opB_mux_sel = 1'b0;
      alu_func    = 3'b000;
      cc_en       = 1'b0;
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_ren = 1'b1;
            stall   = !w_complete;
         end
         S_EXECUTE: begin
            alu_func    = w_is_alu ? w_op : 3'b000;
            opB_mux_sel = w_type || w_is_bcc;
            ext_op      = w_is_bcc;
            shift_op    = (!w_type && !w_is_bcc) ? w_sh : 2'b00;
            srcA        = w_is_bcc ? 3'd7 : w_ra;
            srcB        = w_rb;
            dest        = w_is_bcc ? 3'd7 : w_rd;
            cc_en       = w_is_alu && w_sl;
            reg_write   = w_is_alu || (w_is_bcc && w_cond_true);
         end
         S_MEMORY: begin
            // Load writeback only in the completing cycle: one write per instruction.
            stall     = !w_complete;
            mem_ren   = !w_sl;
            mem_wen   = w_sl;
            reg_write = !w_sl && w_complete;
            dest      = w_rd;
            srcA      = w_rd;
            srcB      = w_rd;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stump_control_ws.sv
// Directed bench for stump_control_ws: instance 0 uses default parameters,
// instance 1 uses WAIT_CYCLES = 2; each is held in reset while the other runs.
module tb_stump_control_ws;

   logic        clk = 1'b0;
   logic        rst0, rst1;
   logic [3:0]  cc;
   logic [15:0] ir;
   logic        mem_ready;

   logic       fet0, exe0, mem0, stall0, ext0, rw0, opb0, ccen0, ren0, wen0;
   logic [2:0] dest0, sa0, sb0, alu0;
   logic [1:0] sh0;
   logic       fet1, exe1, mem1, stall1, ext1, rw1, opb1, ccen1, ren1, wen1;
   logic [2:0] dest1, sa1, sb1, alu1;
   logic [1:0] sh1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stump_control_ws u_dut0 (
      .clk(clk), .rst(rst0), .cc(cc), .ir(ir), .mem_ready(mem_ready),
      .fetch(fet0), .execute(exe0), .memory(mem0), .stall(stall0),
      .ext_op(ext0), .reg_write(rw0), .dest(dest0), .srcA(sa0), .srcB(sb0),
      .shift_op(sh0), .opB_mux_sel(opb0), .alu_func(alu0), .cc_en(ccen0),
      .mem_ren(ren0), .mem_wen(wen0)
   );

   stump_control_ws #(.WAIT_CYCLES(2)) u_dut1 (
      .clk(clk), .rst(rst1), .cc(cc), .ir(ir), .mem_ready(mem_ready),
      .fetch(fet1), .execute(exe1), .memory(mem1), .stall(stall1),
      .ext_op(ext1), .reg_write(rw1), .dest(dest1), .srcA(sa1), .srcB(sb1),
      .shift_op(sh1), .opB_mux_sel(opb1), .alu_func(alu1), .cc_en(ccen1),
      .mem_ren(ren1), .mem_wen(wen1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   localparam int NC = 10;
   localparam logic [3:0] T_COND [NC] = '{4'hE, 4'hD, 4'h2, 4'h3, 4'hB, 4'h9, 4'h1, 4'hF, 4'hC, 4'h5};
   localparam logic [3:0] T_CC   [NC] = '{4'b1010, 4'b1000, 4'b0000, 4'b0000, 4'b1000,
                                          4'b0000, 4'b1111, 4'b0000, 4'b1000, 4'b0001};
   localparam bit         T_EXP  [NC] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      logic [15:0] ir_v;
      rst0 = 1'b1; rst1 = 1'b1; ir = 16'h0000; cc = 4'h0; mem_ready = 1'b1;
      repeat (2) tick();

      // Reset state of instance 0
      check_eq("rst_state", {mem0, exe0, fet0}, 3'b001);
      check_eq("rst_mem_ren", ren0, 1'b1);
      check_eq("rst_reg_write", rw0, 1'b0);
      check_eq("rst_cc_en", ccen0, 1'b0);
      check_eq("rst_mem_wen", wen0, 1'b0);
      $display("[TB] reset state checked");

      // ADD R2,R2,R1 with S=1: two cycles
      rst0 = 1'b0; ir = 16'h0A44; #1;
      check_eq("add_fetch", {mem0, exe0, fet0}, 3'b001);
      check_eq("add_fetch_stall", stall0, 1'b0);
      tick();
      check_eq("add_exec", {mem0, exe0, fet0}, 3'b010);
      check_eq("add_reg_write", rw0, 1'b1);
      check_eq("add_cc_en", ccen0, 1'b1);
      check_eq("add_dest", dest0, 3'd2);
      check_eq("add_alu", alu0, 3'b000);
      check_eq("add_srcA", sa0, 3'd2);
      check_eq("add_srcB", sb0, 3'd1);
      check_eq("add_stall", stall0, 1'b0);
      tick();
      check_eq("add_back_fetch", {mem0, exe0, fet0}, 3'b001);
      $display("[TB] ADD 0x0A44 done");

      // BEQ taken / not taken
      ir = 16'hE705; cc = 4'b0100; tick();
      check_eq("beq_t_exec", {mem0, exe0, fet0}, 3'b010);
      check_eq("beq_t_reg_write", rw0, 1'b1);
      check_eq("beq_t_dest", dest0, 3'd7);
      check_eq("beq_t_ext_op", ext0, 1'b1);
      check_eq("beq_t_srcA", sa0, 3'd7);
      check_eq("beq_t_opB", opb0, 1'b1);
      check_eq("beq_t_cc_en", ccen0, 1'b0);
      tick();
      cc = 4'b0000; tick();
      check_eq("beq_nt_reg_write", rw0, 1'b0);
      tick();
      $display("[TB] BEQ 0xE705 done");

      for (int i = 0; i < NC; i++) begin
         ir_v = {3'b111, 1'b0, T_COND[i], 8'h05};
         ir = ir_v; cc = T_CC[i]; tick();
         check_eq($sformatf("bcc_cond%0h", T_COND[i]), rw0, T_EXP[i]);
         tick();
         $display("[TB] Bcc cond=%0h cc=%b reg_write=%0b", T_COND[i], T_CC[i], rw0);
      end

      // Register-form shift op, S=0
      ir = 16'h4396; tick();
      check_eq("reg_alu", alu0, 3'd2);
      check_eq("reg_shift", sh0, 2'd2);
      check_eq("reg_opB", opb0, 1'b0);
      check_eq("reg_cc_en", ccen0, 1'b0);
      check_eq("reg_dest", dest0, 3'd3);
      check_eq("reg_srcA", sa0, 3'd4);
      check_eq("reg_srcB", sb0, 3'd5);
      tick();
      // Immediate form, S=1
      ir = 16'h3B96; tick();
      check_eq("imm_alu", alu0, 3'd1);
      check_eq("imm_shift", sh0, 2'd0);
      check_eq("imm_opB", opb0, 1'b1);
      check_eq("imm_cc_en", ccen0, 1'b1);
      tick();
      $display("[TB] ALU reg/imm forms done");

      // Store with mem_ready low for 4 MEMORY cycles
      ir = 16'hC920; mem_ready = 1'b1; tick();
      check_eq("st_exec_rw", rw0, 1'b0);
      check_eq("st_exec_alu", alu0, 3'b000);
      mem_ready = 1'b0; tick();
      for (int i = 0; i < 4; i++) begin
         check_eq("st_hold_state", {mem0, exe0, fet0}, 3'b100);
         check_eq("st_hold_wen", wen0, 1'b1);
         check_eq("st_hold_stall", stall0, 1'b1);
         check_eq("st_hold_rw", rw0, 1'b0);
         tick();
      end
      mem_ready = 1'b1; #1;
      check_eq("st_done_state", {mem0, exe0, fet0}, 3'b100);
      check_eq("st_done_stall", stall0, 1'b0);
      check_eq("st_done_wen", wen0, 1'b1);
      tick();
      check_eq("st_to_fetch", {mem0, exe0, fet0}, 3'b001);
      check_eq("st_fetch_wen", wen0, 1'b0);
      $display("[TB] store 0xC920 with ready low done");

      // Random sweep: one-hot state, no writes in FETCH
      for (int i = 0; i < 300; i++) begin
         ir = 16'($urandom); cc = 4'($urandom); mem_ready = 1'($urandom); #1;
         check_eq("rnd_onehot", $onehot({mem0, exe0, fet0}), 1'b1);
         check_eq("rnd_fetch_rw", fet0 & rw0, 1'b0);
         check_eq("rnd_fetch_ccen", fet0 & ccen0, 1'b0);
         check_eq("rnd_fetch_wen", fet0 & wen0, 1'b0);
         tick();
      end
      $display("[TB] random sweep done, failures so far %0d", n_fail);

      // Instance 1: WAIT_CYCLES = 2, load
      rst0 = 1'b1; mem_ready = 1'b1; ir = 16'hC120; cc = 4'h0; tick();
      rst1 = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("ld_fetch_state", {mem1, exe1, fet1}, 3'b001);
         check_eq("ld_fetch_stall", stall1, (i < 2) ? 1'b1 : 1'b0);
         tick();
      end
      check_eq("ld_exec", {mem1, exe1, fet1}, 3'b010);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("ld_mem_state", {mem1, exe1, fet1}, 3'b100);
         check_eq("ld_mem_stall", stall1, (i < 2) ? 1'b1 : 1'b0);
         check_eq("ld_mem_rw", rw1, (i == 2) ? 1'b1 : 1'b0);
         check_eq("ld_mem_ren", ren1, 1'b1);
         check_eq("ld_mem_wen", wen1, 1'b0);
         tick();
      end
      check_eq("ld_to_fetch", {mem1, exe1, fet1}, 3'b001);
      $display("[TB] load 0xC120 WAIT_CYCLES=2 done");

      // Store, reset while stalled in MEMORY
      ir = 16'hC920; repeat (3) tick();
      check_eq("st1_exec", {mem1, exe1, fet1}, 3'b010);
      mem_ready = 1'b0; tick();
      repeat (3) tick();
      check_eq("st1_stalled", stall1, 1'b1);
      check_eq("st1_stalled_wen", wen1, 1'b1);
      rst1 = 1'b1; tick();
      check_eq("rst_mid_fetch", {mem1, exe1, fet1}, 3'b001);
      check_eq("rst_mid_wen", wen1, 1'b0);
      check_eq("rst_mid_ren", ren1, 1'b1);
      rst1 = 1'b0; mem_ready = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_wait_cleared", stall1, (i < 2) ? 1'b1 : 1'b0);
         tick();
      end
      $display("[TB] reset during stalled store done");

      // Saturated counter: access completes as soon as ready rises
      check_eq("sat_exec", {mem1, exe1, fet1}, 3'b010);
      mem_ready = 1'b0; tick();
      repeat (4) tick();
      check_eq("sat_hold", {mem1, exe1, fet1}, 3'b100);
      mem_ready = 1'b1; #1;
      check_eq("sat_complete", stall1, 1'b0);
      tick();
      check_eq("sat_to_fetch", {mem1, exe1, fet1}, 3'b001);
      $display("[TB] wait counter saturation done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
